// File: rtl/vie_sram_bridge.sv
// rtl/vie_sram_bridge.sv - arbitrates inst/data sram-like channels onto one variable-latency memory port
`timescale 1ns/1ps
module vie_sram_bridge #(
    parameter int ARB_MODE = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [31:0] m_addr,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_wdata,
    input  logic        m_gnt,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t      state_q, state_d;
    // owner/last encoding: 0 = inst, 1 = data
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        grant_data, grant_inst;
    logic [3:0]  strb;

    always_comb begin
        grant_data = data_req && (!inst_req || (ARB_MODE != 0) || !last_q);
        grant_inst = inst_req && !grant_data;
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        wr_d         = wr_q;
        size_d       = size_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        m_req        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_data || grant_inst) begin
                    inst_addr_ok = grant_inst;
                    data_addr_ok = grant_data;
                    owner_d      = grant_data;
                    last_d       = grant_data;
                    wr_d         = grant_data ? data_wr    : inst_wr;
                    size_d       = grant_data ? data_size  : inst_size;
                    addr_d       = grant_data ? data_addr  : inst_addr;
                    wdata_d      = grant_data ? data_wdata : inst_wdata;
                    state_d      = S_REQ;
                end
            end
            S_REQ: begin
                m_req = 1'b1;
                if (m_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (m_rvalid) begin
                    inst_data_ok = !owner_q;
                    data_data_ok = owner_q;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // half accesses ignore addr[0]; misalignment is the requester's problem
    always_comb begin
        case (size_q)
            2'd0:    strb = 4'b0001 << addr_q[1:0];
            2'd1:    strb = addr_q[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
    end

    always_comb begin
        m_wr       = wr_q;
        m_addr     = {addr_q[31:2], 2'b00};
        m_wstrb    = wr_q ? strb : 4'b0000;
        m_wdata    = wdata_q;
        inst_rdata = inst_data_ok ? m_rdata : 32'h0;
        data_rdata = data_data_ok ? m_rdata : 32'h0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: tb/tb_vie_sram_bridge.sv
// tb/tb_vie_sram_bridge.sv - directed self-checking bench for vie_sram_bridge
`timescale 1ns/1ps
module tb_vie_sram_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        m_gnt, m_rvalid;
    logic [31:0] m_rdata;

    logic        a_inst_addr_ok, a_inst_data_ok, a_data_addr_ok, a_data_data_ok;
    logic [31:0] a_inst_rdata, a_data_rdata;
    logic        a_m_req, a_m_wr;
    logic [31:0] a_m_addr, a_m_wdata;
    logic [3:0]  a_m_wstrb;

    logic        f_inst_addr_ok, f_inst_data_ok, f_data_addr_ok, f_data_data_ok;
    logic [31:0] f_inst_rdata, f_data_rdata;
    logic        f_m_req, f_m_wr;
    logic [31:0] f_m_addr, f_m_wdata;
    logic [3:0]  f_m_wstrb;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vie_sram_bridge #(.ARB_MODE(0)) u_rr (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(a_inst_addr_ok), .inst_data_ok(a_inst_data_ok), .inst_rdata(a_inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(a_data_addr_ok), .data_data_ok(a_data_data_ok), .data_rdata(a_data_rdata),
        .m_req(a_m_req), .m_wr(a_m_wr), .m_addr(a_m_addr), .m_wstrb(a_m_wstrb), .m_wdata(a_m_wdata),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    vie_sram_bridge #(.ARB_MODE(1)) u_fp (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(f_inst_addr_ok), .inst_data_ok(f_inst_data_ok), .inst_rdata(f_inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(f_data_addr_ok), .data_data_ok(f_data_data_ok), .data_rdata(f_data_rdata),
        .m_req(f_m_req), .m_wr(f_m_wr), .m_addr(f_m_addr), .m_wstrb(f_m_wstrb), .m_wdata(f_m_wdata),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    task automatic idle_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        m_gnt = 0; m_rvalid = 0; m_rdata = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 0;
        #3;
        resetn = 1;
        @(posedge clk); #1;
    endtask

    // Zero-wait transaction on one channel (side: 0 inst, 1 data); starts and ends at posedge+1.
    task automatic run_txn(input logic side, input logic wr, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input logic [31:0] exp_addr,
                           input logic [3:0] exp_strb, input string name);
        logic [1:0] exp_pair;
        exp_pair = side ? 2'b01 : 2'b10;
        if (side) begin
            data_req = 1; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wdata;
        end else begin
            inst_req = 1; inst_wr = wr; inst_size = size; inst_addr = addr; inst_wdata = wdata;
        end
        @(negedge clk);
        n_vec++;
        if ({a_inst_addr_ok, a_data_addr_ok} !== exp_pair) begin
            n_err++;
            $display("FAIL %s addr_ok: got %b expected %b", name, {a_inst_addr_ok, a_data_addr_ok}, exp_pair);
        end
        @(posedge clk); #1;
        inst_req = 0; data_req = 0; m_gnt = 1;
        @(negedge clk);
        n_vec++;
        if ({a_m_req, a_m_wr, a_m_addr, a_m_wstrb} !== {1'b1, wr, exp_addr, exp_strb}) begin
            n_err++;
            $display("FAIL %s m_fields: got req=%b wr=%b addr=%h wstrb=%b expected req=1 wr=%b addr=%h wstrb=%b",
                     name, a_m_req, a_m_wr, a_m_addr, a_m_wstrb, wr, exp_addr, exp_strb);
        end
        if (wr) begin
            n_vec++;
            if (a_m_wdata !== wdata) begin
                n_err++;
                $display("FAIL %s m_wdata: got %h expected %h", name, a_m_wdata, wdata);
            end
        end
        @(posedge clk); #1;
        m_gnt = 0; m_rvalid = 1; m_rdata = rdata;
        @(negedge clk);
        n_vec++;
        if ({a_inst_data_ok, a_data_data_ok} !== exp_pair
            || (side ? a_data_rdata : a_inst_rdata) !== rdata) begin
            n_err++;
            $display("FAIL %s data_ok: got ok=%b rdata=%h expected ok=%b rdata=%h", name,
                     {a_inst_data_ok, a_data_data_ok}, side ? a_data_rdata : a_inst_rdata, exp_pair, rdata);
        end
        @(posedge clk); #1;
        m_rvalid = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({a_m_req, a_m_wr, a_m_addr, a_m_wstrb, a_m_wdata} !== 70'h0) begin
            n_err++;
            $display("FAIL reset_m: got req=%b wr=%b addr=%h wstrb=%b wdata=%h expected all 0",
                     a_m_req, a_m_wr, a_m_addr, a_m_wstrb, a_m_wdata);
        end
        n_vec++;
        if ({a_inst_addr_ok, a_data_addr_ok, a_inst_data_ok, a_data_data_ok, a_inst_rdata, a_data_rdata} !== 68'h0) begin
            n_err++;
            $display("FAIL reset_slave: got ok=%b irdata=%h drdata=%h expected all 0",
                     {a_inst_addr_ok, a_data_addr_ok, a_inst_data_ok, a_data_data_ok}, a_inst_rdata, a_data_rdata);
        end
        resetn = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_read();
        run_txn(1'b1, 1'b0, 2'd2, 32'h1000_0004, 32'h0, 32'hDEAD_BEEF, 32'h1000_0004, 4'b0000, "single_read");
        @(negedge clk);
        n_vec++;
        if ({a_m_req, a_inst_data_ok, a_data_data_ok} !== 3'b000) begin
            n_err++;
            $display("FAIL single_read_after: got req/iok/dok=%b expected 000", {a_m_req, a_inst_data_ok, a_data_data_ok});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_strobes();
        run_txn(1'b1, 1'b1, 2'd0, 32'h2000_0003, 32'h1100_0000, 32'h0, 32'h2000_0000, 4'b1000, "byte3");
        run_txn(1'b0, 1'b1, 2'd0, 32'h2000_0001, 32'h0000_2200, 32'h0, 32'h2000_0000, 4'b0010, "byte1");
        run_txn(1'b1, 1'b1, 2'd1, 32'h2000_0002, 32'h3333_0000, 32'h0, 32'h2000_0000, 4'b1100, "half2");
        run_txn(1'b0, 1'b1, 2'd1, 32'h2000_0001, 32'h0000_4444, 32'h0, 32'h2000_0000, 4'b0011, "half1");
        run_txn(1'b1, 1'b1, 2'd2, 32'h2000_0008, 32'h5566_7788, 32'h0, 32'h2000_0008, 4'b1111, "word");
        run_txn(1'b0, 1'b1, 2'd3, 32'h2000_000C, 32'h99AA_BBCC, 32'h0, 32'h2000_000C, 4'b1111, "word_sz3");
        run_txn(1'b1, 1'b0, 2'd0, 32'h2000_0003, 32'h0, 32'h0123_4567, 32'h2000_0000, 4'b0000, "read");
    endtask

    task automatic test_backpressure();
        int ok_cnt;
        ok_cnt = 0;
        data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h3000_0010; data_wdata = 32'hA5A5_5A5A;
        @(negedge clk);
        n_vec++;
        if ({a_inst_addr_ok, a_data_addr_ok} !== 2'b01) begin
            n_err++;
            $display("FAIL bp_accept: got %b expected 01", {a_inst_addr_ok, a_data_addr_ok});
        end
        @(posedge clk); #1;
        inst_req = 1; inst_addr = 32'h0000_0050;
        for (int c = 0; c < 6; c++) begin
            if (c == 5) m_gnt = 1;
            @(negedge clk);
            n_vec++;
            if ({a_m_req, a_m_wr, a_m_addr, a_m_wstrb, a_m_wdata, a_inst_addr_ok, a_data_addr_ok}
                !== {1'b1, 1'b1, 32'h3000_0010, 4'b1111, 32'hA5A5_5A5A, 2'b00}) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got req=%b wr=%b addr=%h wstrb=%b wdata=%h addr_ok=%b expected 1 1 30000010 1111 a5a55a5a 00",
                         c, a_m_req, a_m_wr, a_m_addr, a_m_wstrb, a_m_wdata, {a_inst_addr_ok, a_data_addr_ok});
            end
            @(posedge clk); #1;
        end
        m_gnt = 0;
        for (int c = 0; c < 5; c++) begin
            m_rvalid = (c == 3);
            if (c == 4) begin
                inst_req = 0; data_req = 0;
            end
            @(negedge clk);
            if (a_data_data_ok || a_inst_data_ok) ok_cnt++;
            if (c < 4) begin
                n_vec++;
                if ({a_m_req, a_inst_addr_ok, a_data_addr_ok} !== 3'b000) begin
                    n_err++;
                    $display("FAIL bp_wait[%0d]: got req/addr_ok=%b expected 000", c, {a_m_req, a_inst_addr_ok, a_data_addr_ok});
                end
            end
            @(posedge clk); #1;
        end
        m_rvalid = 0;
        n_vec++;
        if (ok_cnt !== 1) begin
            n_err++;
            $display("FAIL bp_data_ok_count: got %0d expected 1", ok_cnt);
        end
    endtask

    task automatic test_reset_mid();
        data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h4000_0008;
        @(posedge clk); #1;
        data_req = 0; m_gnt = 1;
        @(posedge clk); #1;
        m_gnt = 0;
        #2;
        resetn = 0;
        #1;
        n_vec++;
        if ({a_m_req, a_m_wr, a_m_addr, a_m_wstrb, a_m_wdata, a_inst_addr_ok, a_data_addr_ok,
             a_inst_data_ok, a_data_data_ok, a_inst_rdata, a_data_rdata} !== 138'h0) begin
            n_err++;
            $display("FAIL reset_mid_outputs: got req=%b addr=%h ok=%b expected all 0",
                     a_m_req, a_m_addr, {a_inst_addr_ok, a_data_addr_ok, a_inst_data_ok, a_data_data_ok});
        end
        @(negedge clk);
        resetn = 1;
        @(posedge clk); #1;
        m_rvalid = 1; m_rdata = 32'h1234_5678;
        @(negedge clk);
        n_vec++;
        if ({a_m_req, a_inst_data_ok, a_data_data_ok, a_data_rdata} !== 35'h0) begin
            n_err++;
            $display("FAIL reset_mid_stray_rvalid: got req/iok/dok=%b drdata=%h expected 000 0",
                     {a_m_req, a_inst_data_ok, a_data_data_ok}, a_data_rdata);
        end
        @(posedge clk); #1;
        m_rvalid = 0;
        run_txn(1'b0, 1'b0, 2'd2, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 32'h0000_0040, 4'b0000, "after_reset");
    endtask

    task automatic test_tie_rr();
        logic [1:0] exp_pair;
        do_reset();
        inst_req = 1; inst_addr = 32'h0000_0100;
        data_req = 1; data_addr = 32'h0000_0200; data_size = 2; inst_size = 2;
        for (int k = 0; k < 4; k++) begin
            exp_pair = (k % 2 == 0) ? 2'b01 : 2'b10;
            @(negedge clk);
            n_vec++;
            if ({a_inst_addr_ok, a_data_addr_ok} !== exp_pair) begin
                n_err++;
                $display("FAIL rr_grant[%0d]: got %b expected %b", k, {a_inst_addr_ok, a_data_addr_ok}, exp_pair);
            end
            @(posedge clk); #1;
            m_gnt = 1;
            @(negedge clk);
            n_vec++;
            if (a_m_addr !== (exp_pair[0] ? 32'h0000_0200 : 32'h0000_0100)) begin
                n_err++;
                $display("FAIL rr_addr[%0d]: got %h expected %h", k, a_m_addr,
                         exp_pair[0] ? 32'h0000_0200 : 32'h0000_0100);
            end
            @(posedge clk); #1;
            m_gnt = 0; m_rvalid = 1; m_rdata = 32'hB000_0000 + k;
            @(negedge clk);
            n_vec++;
            if ({a_inst_data_ok, a_data_data_ok} !== exp_pair) begin
                n_err++;
                $display("FAIL rr_data_ok[%0d]: got %b expected %b", k, {a_inst_data_ok, a_data_data_ok}, exp_pair);
            end
            @(posedge clk); #1;
            m_rvalid = 0;
            if (k == 3) begin
                inst_req = 0; data_req = 0;
            end
        end
    endtask

    task automatic test_fixed_prio();
        do_reset();
        inst_req = 1; inst_addr = 32'h0000_0300;
        data_req = 1; data_addr = 32'h0000_0400;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) data_req = 0;
            @(negedge clk);
            n_vec++;
            if ({f_inst_addr_ok, f_data_addr_ok} !== ((k < 3) ? 2'b01 : 2'b10)) begin
                n_err++;
                $display("FAIL fp_grant[%0d]: got %b expected %b", k, {f_inst_addr_ok, f_data_addr_ok},
                         (k < 3) ? 2'b01 : 2'b10);
            end
            @(posedge clk); #1;
            m_gnt = 1;
            if (k == 3) inst_req = 0;
            @(posedge clk); #1;
            m_gnt = 0; m_rvalid = 1; m_rdata = 32'hC000_0000 + k;
            @(negedge clk);
            n_vec++;
            if ({f_inst_data_ok, f_data_data_ok} !== ((k < 3) ? 2'b01 : 2'b10)) begin
                n_err++;
                $display("FAIL fp_data_ok[%0d]: got %b expected %b", k, {f_inst_data_ok, f_data_data_ok},
                         (k < 3) ? 2'b01 : 2'b10);
            end
            @(posedge clk); #1;
            m_rvalid = 0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        resetn = 0;
        test_reset();
        test_single_read();
        test_strobes();
        test_backpressure();
        test_reset_mid();
        test_tie_rr();
        test_fixed_prio();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vie_sram_bridge.md
# vie_sram_bridge

Two-port to one-port memory bridge downstream of `mycpu_top`. It accepts instruction-side and data-side requests on independent sram-like channels with an `addr_ok`/`data_ok` handshake. It arbitrates between them and issues one transaction at a time on a single variable-latency memory port. This lets the CPU core share one physical memory or bus adapter.

## Interface
Parameters:
- `ARB_MODE`, default 0: 0 selects round-robin on a tie; 1 selects fixed data-side priority.

Ports (X ∈ {inst, data}; one slave channel each):
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `X_req`  in  1  request valid; held until `X_addr_ok`.
- `X_wr`  in  1  1 = write, 0 = read.
- `X_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = word.
- `X_addr`  in  32  byte address.
- `X_wdata`  in  32  write data, already lane-aligned by the requester.
- `X_addr_ok`  out  1  request accepted this cycle.
- `X_data_ok`  out  1  one-cycle pulse: read data valid, or write complete.
- `X_rdata`  out  32  read data; meaningful only while `X_data_ok` is high.
- `m_req`  out  1  memory request; held until `m_gnt`.
- `m_wr`  out  1  write flag.
- `m_addr`  out  32  address, with `[1:0]` forced to 0.
- `m_wstrb`  out  4  byte strobes; all zero for reads.
- `m_wdata`  out  32  write data.
- `m_gnt`  in  1  memory accepts `m_req` this cycle.
- `m_rvalid`  in  1  response: read data valid, or write done.
- `m_rdata`  in  32  read data.

## Operation
- FSM states: IDLE, REQ, WAIT. Reset state is IDLE.
- IDLE:
  - If any `X_req` is high, grant exactly one channel. `X_addr_ok` is high combinationally in the same cycle.
  - Latch `wr`, `size`, `addr`, `wdata` and the owner id. Go to REQ.
- REQ:
  - `m_req` = 1, driven from the latched fields. All `addr_ok` are 0.
  - On `m_gnt`, go to WAIT.
- WAIT:
  - `m_req` = 0. Wait for `m_rvalid`.
  - On `m_rvalid`, the owner's `data_ok` = 1 and its `rdata` = `m_rdata` (combinational pass-through). Go to IDLE.
  - `m_rvalid` outside WAIT is ignored.
- Arbitration on a tie (both `req` high in IDLE):
  - `ARB_MODE`=0: grant the channel not granted last. The `last` pointer resets to inst, so data wins the first tie.
  - `ARB_MODE`=1: data always wins.
  - A single requester is always granted.
- Strobe generation for writes, from `size` and `addr[1:0]`:
  - byte: `4'b0001 << addr[1:0]`.
  - half: `addr[1]` ? `4'b1100` : `4'b0011`.
  - word: `4'b1111`.
  - Misalignment is not checked. For a half access, `addr[0]` is ignored.
- At most one transaction is outstanding in the block. No request buffering beyond the single latch.
- Reset (`resetn` low at any time, including in REQ or WAIT):
  - State goes to IDLE, `last` to inst, latches to 0.
  - The in-flight transaction is dropped with no `data_ok`.

## Timing
- Reset values: all outputs 0 (`m_req`, `m_wr`, `m_addr`, `m_wstrb`, `m_wdata`, every `addr_ok`/`data_ok`/`rdata`).
- Best case:
  - cycle 0: `X_req` and `X_addr_ok`.
  - cycle 1: `m_req`, with `m_gnt` in the same cycle.
  - cycle 2: `m_rvalid` and `X_data_ok`.
- A new request can be accepted at the earliest in the cycle after `data_ok`, because IDLE is re-entered at that edge.
- Sustained throughput is 1 transaction per 3 cycles with zero memory wait.
- `m_*` outputs are stable from the cycle REQ is entered until `m_gnt`.
- A `req` that is not granted receives no `addr_ok`. The requester must keep it asserted.

## Test plan
- Single read:
  - Stimulus: `data_req`=1, `wr`=0, `addr`=0x1000_0004; `m_gnt` on cycle 1; `m_rvalid` on cycle 2 with `m_rdata`=0xDEAD_BEEF.
  - Required: `data_addr_ok` on cycle 0; `m_addr`=0x1000_0004; `data_data_ok` on cycle 2 with `rdata`=0xDEAD_BEEF; `inst_data_ok` stays 0.
- Byte and half write strobes:
  - byte write to 0x...03 → `m_wstrb`=0b1000.
  - half write to 0x...02 → 0b1100.
  - word write → 0b1111.
  - read → 0b0000.
- Tie, round-robin (`ARB_MODE`=0):
  - Stimulus: both channels request continuously.
  - Required: grants alternate data, inst, data, inst; each `data_ok` goes only to its owner.
- Tie, fixed priority (`ARB_MODE`=1):
  - Stimulus: both channels request for 3 transactions.
  - Required: data granted all 3; inst granted only once data deasserts.
- Backpressure:
  - Stimulus: `m_gnt` held low 5 cycles, then `m_rvalid` 4 cycles after grant.
  - Required: `m_req` and fields stable throughout; no second `addr_ok`; exactly one `data_ok`.
- Reset mid-operation:
  - Stimulus: assert `resetn`=0 asynchronously while in WAIT; release; then pulse `m_rvalid`.
  - Required: all outputs 0 immediately; no `data_ok`; the next request is granted from IDLE normally.
